// File: rtl/ar_rr_arbiter.sv
// ar_rr_arbiter: round-robin arbiter sharing one AXI AR request path among
// NUM_SRC masters. The winning beat is captured into a single-entry output
// register and presented downstream with the index of its source.
//
// Optional build macro: AR_ARB_QOS_EN
//   defined   - only valid sources carrying the highest in_qos are eligible;
//               round-robin order is applied within that set.
//   undefined - pure round-robin; in_qos is only carried through to out_qos.

module ar_rr_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int ID_WIDTH    = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC-1:0]               in_valid,
    output logic [NUM_SRC-1:0]               in_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]      in_id,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    in_addr,
    input  logic [NUM_SRC*LEN_WIDTH-1:0]     in_len,
    input  logic [NUM_SRC*SIZE_WIDTH-1:0]    in_size,
    input  logic [NUM_SRC*BURST_WIDTH-1:0]   in_burst,
    input  logic [NUM_SRC*QOS_WIDTH-1:0]     in_qos,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ID_WIDTH-1:0]              out_id,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    output logic [LEN_WIDTH-1:0]             out_len,
    output logic [SIZE_WIDTH-1:0]            out_size,
    output logic [BURST_WIDTH-1:0]           out_burst,
    output logic [QOS_WIDTH-1:0]             out_qos,
    output logic [$clog2(NUM_SRC)-1:0]       out_src
);

    localparam int SRC_W = $clog2(NUM_SRC);

    // Per-source views of the packed request fields
    logic [ID_WIDTH-1:0]    id_arr    [NUM_SRC];
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_SRC];
    logic [LEN_WIDTH-1:0]   len_arr   [NUM_SRC];
    logic [SIZE_WIDTH-1:0]  size_arr  [NUM_SRC];
    logic [BURST_WIDTH-1:0] burst_arr [NUM_SRC];
    logic [QOS_WIDTH-1:0]   qos_arr   [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign id_arr[gi]    = in_id[gi*ID_WIDTH +: ID_WIDTH];
            assign addr_arr[gi]  = in_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign len_arr[gi]   = in_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign size_arr[gi]  = in_size[gi*SIZE_WIDTH +: SIZE_WIDTH];
            assign burst_arr[gi] = in_burst[gi*BURST_WIDTH +: BURST_WIDTH];
            assign qos_arr[gi]   = in_qos[gi*QOS_WIDTH +: QOS_WIDTH];
        end
    endgenerate

    // Output holding register and round-robin pointer
    logic                   out_valid_reg;
    logic [ID_WIDTH-1:0]    out_id_reg;
    logic [ADDR_WIDTH-1:0]  out_addr_reg;
    logic [LEN_WIDTH-1:0]   out_len_reg;
    logic [SIZE_WIDTH-1:0]  out_size_reg;
    logic [BURST_WIDTH-1:0] out_burst_reg;
    logic [QOS_WIDTH-1:0]   out_qos_reg;
    logic [SRC_W-1:0]       out_src_reg;
    logic [SRC_W-1:0]       last_grant_reg;

    // Sources allowed to compete this cycle
    logic [NUM_SRC-1:0]     eligible;

`ifdef AR_ARB_QOS_EN
    logic [QOS_WIDTH-1:0]   max_qos;

    // Highest qos among the sources currently requesting
    always_comb begin
        max_qos = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_valid[i] && (qos_arr[i] > max_qos)) begin
                max_qos = qos_arr[i];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_elig
            assign eligible[gi] = in_valid[gi] && (qos_arr[gi] == max_qos);
        end
    endgenerate
`else
    assign eligible = in_valid;
`endif

    // Winner: first eligible source after the last grant, wrapping around.
    // The first pass covers indices above the pointer, the second wraps to
    // the indices at or below it, which yields the modulo scan order.
    logic             win_found;
    logic [SRC_W-1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_found && eligible[i] && (SRC_W'(i) > last_grant_reg)) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_found && eligible[i] && (SRC_W'(i) <= last_grant_reg)) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(i);
            end
        end
    end

    // The slot can take a beat when empty or being drained this cycle
    logic slot_free;
    logic load;

    assign slot_free = ~out_valid_reg | out_ready;
    assign load      = slot_free & win_found;

    // One-hot ready toward the winner; held low throughout reset
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign in_ready[gi] = rst_n & load & (win_idx == SRC_W'(gi));
        end
    endgenerate

    // Capture the winning beat, drain on pop, advance the pointer on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_id_reg     <= '0;
            out_addr_reg   <= '0;
            out_len_reg    <= '0;
            out_size_reg   <= '0;
            out_burst_reg  <= '0;
            out_qos_reg    <= '0;
            out_src_reg    <= '0;
            last_grant_reg <= SRC_W'(NUM_SRC - 1);
        end else if (load) begin
            out_valid_reg  <= 1'b1;
            out_id_reg     <= id_arr[win_idx];
            out_addr_reg   <= addr_arr[win_idx];
            out_len_reg    <= len_arr[win_idx];
            out_size_reg   <= size_arr[win_idx];
            out_burst_reg  <= burst_arr[win_idx];
            out_qos_reg    <= qos_arr[win_idx];
            out_src_reg    <= win_idx;
            last_grant_reg <= win_idx;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_id    = out_id_reg;
    assign out_addr  = out_addr_reg;
    assign out_len   = out_len_reg;
    assign out_size  = out_size_reg;
    assign out_burst = out_burst_reg;
    assign out_qos   = out_qos_reg;
    assign out_src   = out_src_reg;

endmodule
